icache_refill_unit: RTL and testbench
=====================================

Name: icache_refill_unit

Overview:
- Miss-handling back end of the instruction cache; the consumer of the ICACHE geometry that `build_config` produces.
- Accepts one miss request at a time, issues a line-aligned read to memory, and collects the line as BEATS = LINE_WIDTH/BUS_WIDTH response beats.
- Presents the assembled line, index, tag and way to the cache arrays as a one-cycle write pulse.
- A flush aborts the writeback but always drains the memory transaction.

Parameters:
- PLEN, 32, physical address width (cfg_t.PLEN)
- LINE_WIDTH, 256, cache line width in bits (cfg_t.ICACHE_LINE_WIDTH)
- INDEX_WIDTH, 6, set index width (cfg_t.ICACHE_INDEX_WIDTH)
- SET_ASSOC, 4, number of ways (cfg_t.ICACHE_SET_ASSOC)
- BUS_WIDTH, 64, memory response data width; LINE_WIDTH must be a multiple of it
- Derived constants:
  - OFFSET_W = log2(LINE_WIDTH/8)
  - TAG_W = PLEN-INDEX_WIDTH-OFFSET_W
  - WAY_W = max(1, log2(SET_ASSOC))

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  abort current refill (no array write)
miss_valid_i  in  1  miss request valid
miss_ready_o  out  1  unit idle, can accept a miss
miss_paddr_i  in  PLEN  missing physical address
miss_way_i  in  WAY_W  victim way chosen by the cache
mem_req_valid_o  out  1  memory read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  PLEN  line-aligned read address
mem_rsp_valid_i  in  1  response beat valid (no backpressure)
mem_rsp_data_i  in  BUS_WIDTH  response beat data
mem_rsp_err_i  in  1  bus error on this beat
refill_valid_o  out  1  one-cycle array write strobe
refill_index_o  out  INDEX_WIDTH  set index
refill_tag_o  out  TAG_W  tag
refill_way_o  out  WAY_W  way
refill_data_o  out  LINE_WIDTH  assembled line
refill_err_o  out  1  line contains at least one errored beat

Behaviour:
- Reset state, asserted asynchronously:
  - state=IDLE.
  - All registers are cleared: addr, way, beat counter, line buffer, error flag, abort flag.
  - All outputs are 0 except miss_ready_o=1.
- Reset mid-refill drops the transaction silently. The memory side is reset with the same signal.
- States are IDLE, REQ, RECV, WRITE.
- IDLE:
  - miss_ready_o=1.
  - On miss_valid_i the unit latches the address with bits [OFFSET_W-1:0] cleared, latches miss_way_i, and clears the counter, error flag and abort flag.
  - Next state is REQ.
- REQ:
  - mem_req_valid_o=1 with mem_req_addr_o = latched address.
  - Valid, once raised, is never retracted, even under flush.
  - On mem_req_ready_i the next state is RECV.
  - A response beat arriving in the same cycle as acceptance is impossible by protocol and is ignored.
- RECV:
  - Each mem_rsp_valid_i beat writes line[cnt*BUS_WIDTH +: BUS_WIDTH], so beat 0 lands at the LSBs.
  - The beat counter increments; the error flag becomes err |= mem_rsp_err_i.
  - On the beat with cnt==BEATS-1, the next state is WRITE.
  - Cycles with no valid beat hold the current state.
- WRITE (exactly one cycle, then IDLE):
  - refill_valid_o = !abort && !flush_i.
  - refill_index_o = addr[OFFSET_W +: INDEX_WIDTH].
  - refill_tag_o = addr[PLEN-1 -: TAG_W].
  - refill_data_o = line buffer; refill_err_o = error flag.
- The refill_* data outputs are held stable from WRITE until the next miss is accepted.
- flush_i handling:
  - Sets the sticky abort flag in REQ, RECV or WRITE.
  - Has no effect in IDLE; a flush coinciding with miss acceptance does not abort the new miss.
  - An aborted refill still completes REQ and consumes all BEATS beats, but refill_valid_o stays 0.
- Timing with ready and beats arriving back-to-back:
  - Miss accepted at cycle 0.
  - Request valid at cycle 1.
  - Beats at cycles 2..BEATS+1.
  - refill_valid_o at cycle BEATS+2.
  - miss_ready_o at cycle BEATS+3.
- Counter width is log2(BEATS), minimum 1 bit. With BEATS==1, RECV proceeds to WRITE on the first beat.

Test Plan:
- Basic refill (defaults, so BEATS=4):
  - Stimulus: miss paddr 0x8000_1234, way 2; ready immediate; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - Response: mem_req_addr_o = 0x8000_1220. refill_valid_o is high exactly 1 cycle, at cycle 6. index = 0x11, tag = 0x100002, way = 2, data = {0x44..44, 0x33..33, 0x22..22, 0x11..11}, err = 0.
- Stalls:
  - Stimulus: mem_req_ready_i held low for 3 cycles; a 2-cycle gap between beats 1 and 2.
  - Response: mem_req_valid_o and mem_req_addr_o are stable throughout the wait. The line is identical to the basic case. miss_ready_o stays 0 until the cycle after WRITE.
- Error:
  - Stimulus: mem_rsp_err_i=1 on beat 2 only.
  - Response: refill_valid_o=1 with refill_err_o=1. The next clean miss reports err=0.
- Flush during RECV:
  - Stimulus: flush_i pulse after beat 1.
  - Response: the remaining 2 beats are consumed, refill_valid_o never asserts, and miss_ready_o returns. A following miss refills normally.
- Flush in REQ and in WRITE:
  - Flush while mem_req_ready_i=0: the request stays asserted until accepted and no refill occurs.
  - Flush in the WRITE cycle: refill_valid_o=0.
- Async reset in RECV:
  - Stimulus: rst_ni low mid-cycle after beat 2.
  - Response: outputs immediately return to reset values (miss_ready_o=1, others 0). A new miss is accepted right after release.

Source files
------------

// File: rtl/icache_refill_unit.sv
// icache_refill_unit
//
// Miss-handling back end of the instruction cache. It takes one miss at a
// time and issues a single line-aligned read to memory. It then collects the
// line as BEATS response beats and hands the assembled line to the cache
// arrays as a one-cycle write strobe. A flush suppresses that write but the
// memory transaction is always drained, so the memory side never sees an
// abandoned read.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             abort the refill in flight (no array write)
//   miss_valid_i        miss request valid
//   miss_ready_o        unit idle, can accept a miss
//   miss_paddr_i        missing physical address
//   miss_way_i          victim way chosen by the cache
//   mem_req_valid_o     memory read request valid
//   mem_req_ready_i     memory accepts the request
//   mem_req_addr_o      line-aligned read address
//   mem_rsp_valid_i     response beat valid (no backpressure)
//   mem_rsp_data_i      response beat data
//   mem_rsp_err_i       bus error on this beat
//   refill_valid_o      one-cycle array write strobe
//   refill_index_o      set index
//   refill_tag_o        tag
//   refill_way_o        way
//   refill_data_o       assembled line, beat 0 in the LSBs
//   refill_err_o        line contains at least one errored beat
module icache_refill_unit #(
  parameter int PLEN        = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int INDEX_WIDTH = 6,
  parameter int SET_ASSOC   = 4,
  parameter int BUS_WIDTH   = 64,
  localparam int OFFSET_W   = $clog2(LINE_WIDTH / 8),
  localparam int TAG_W      = PLEN - INDEX_WIDTH - OFFSET_W,
  localparam int WAY_W      = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   miss_valid_i,
  output logic                   miss_ready_o,
  input  logic [PLEN-1:0]        miss_paddr_i,
  input  logic [WAY_W-1:0]       miss_way_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [PLEN-1:0]        mem_req_addr_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [BUS_WIDTH-1:0]   mem_rsp_data_i,
  input  logic                   mem_rsp_err_i,
  output logic                   refill_valid_o,
  output logic [INDEX_WIDTH-1:0] refill_index_o,
  output logic [TAG_W-1:0]       refill_tag_o,
  output logic [WAY_W-1:0]       refill_way_o,
  output logic [LINE_WIDTH-1:0]  refill_data_o,
  output logic                   refill_err_o
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    WRITE
  } state_t;

  state_t                 state_q, state_d;
  logic [PLEN-1:0]        addr_q;
  logic [WAY_W-1:0]       way_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LINE_WIDTH-1:0]  line_q;
  logic                   err_q;
  logic                   abort_q;
  logic                   last_beat;
  logic                   accept_miss;
  logic [PLEN-1:0]        aligned_paddr;

  // The byte-offset bits of the miss address are deliberately discarded:
  // the read is always for the whole line.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_paddr_i[OFFSET_W-1:0];

  assign aligned_paddr = {miss_paddr_i[PLEN-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign last_beat     = (cnt_q == CNT_W'(BEATS - 1));
  assign accept_miss   = (state_q == IDLE) && miss_valid_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake/strobe outputs. The request valid is a
  // pure function of the REQ state, so once raised it cannot drop before
  // acceptance, even under flush.
  always_comb begin
    state_d         = state_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    refill_valid_o  = 1'b0;

    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = addr_q;
        if (mem_req_ready_i) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (mem_rsp_valid_i && last_beat) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        refill_valid_o = !abort_q && !flush_i;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Miss context and line assembly. Context is only rewritten when a new
  // miss is accepted, which is what keeps the refill_* outputs stable
  // between the WRITE cycle and the next miss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (accept_miss) begin
        addr_q  <= aligned_paddr;
        way_q   <= miss_way_i;
        cnt_q   <= '0;
        err_q   <= 1'b0;
        abort_q <= 1'b0;
      end

      // Abort is sticky for the rest of the transaction; a flush seen in
      // IDLE is ignored so it cannot poison a miss accepted in that cycle.
      if ((state_q != IDLE) && flush_i) begin
        abort_q <= 1'b1;
      end

      // Beats are only consumed in RECV; any beat in the REQ acceptance
      // cycle is a protocol violation and is ignored.
      if ((state_q == RECV) && mem_rsp_valid_i) begin
        for (int b = 0; b < BEATS; b++) begin
          if (cnt_q == CNT_W'(b)) begin
            line_q[b*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
          end
        end
        cnt_q <= cnt_q + 1'b1;
        err_q <= err_q | mem_rsp_err_i;
      end
    end
  end

  assign refill_index_o = addr_q[OFFSET_W +: INDEX_WIDTH];
  assign refill_tag_o   = addr_q[PLEN-1 -: TAG_W];
  assign refill_way_o   = way_q;
  assign refill_data_o  = line_q;
  assign refill_err_o   = err_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// tb_icache_refill_unit
//
// Scoreboard bench for icache_refill_unit at default parameters (BEATS=4).
// applyStimulus drives one miss plus the memory side and pushes the refill
// it expects. A monitor pops that entry when refill_valid_o fires and
// compares the written fields.
module tb_icache_refill_unit;

  localparam int PLEN        = 32;
  localparam int LINE_WIDTH  = 256;
  localparam int INDEX_WIDTH = 6;
  localparam int SET_ASSOC   = 4;
  localparam int BUS_WIDTH   = 64;
  localparam int BEATS       = 4;
  localparam int TAG_W       = 21;
  localparam int WAY_W       = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   flush_i;
  logic                   miss_valid_i;
  logic                   miss_ready_o;
  logic [PLEN-1:0]        miss_paddr_i;
  logic [WAY_W-1:0]       miss_way_i;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [PLEN-1:0]        mem_req_addr_o;
  logic                   mem_rsp_valid_i;
  logic [BUS_WIDTH-1:0]   mem_rsp_data_i;
  logic                   mem_rsp_err_i;
  logic                   refill_valid_o;
  logic [INDEX_WIDTH-1:0] refill_index_o;
  logic [TAG_W-1:0]       refill_tag_o;
  logic [WAY_W-1:0]       refill_way_o;
  logic [LINE_WIDTH-1:0]  refill_data_o;
  logic                   refill_err_o;

  typedef struct {
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_W-1:0]       tag;
    logic [WAY_W-1:0]       way;
    logic [LINE_WIDTH-1:0]  data;
    logic                   err;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   error_count = 0;

  icache_refill_unit #(
    .PLEN       (PLEN),
    .LINE_WIDTH (LINE_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH),
    .SET_ASSOC  (SET_ASSOC),
    .BUS_WIDTH  (BUS_WIDTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .miss_valid_i   (miss_valid_i),
    .miss_ready_o   (miss_ready_o),
    .miss_paddr_i   (miss_paddr_i),
    .miss_way_i     (miss_way_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .mem_rsp_err_i  (mem_rsp_err_i),
    .refill_valid_o (refill_valid_o),
    .refill_index_o (refill_index_o),
    .refill_tag_o   (refill_tag_o),
    .refill_way_o   (refill_way_o),
    .refill_data_o  (refill_data_o),
    .refill_err_o   (refill_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [LINE_WIDTH-1:0] observed,
                             input logic [LINE_WIDTH-1:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks every reset-valued output while reset is held.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miss_ready"}, miss_ready_o, 1);
    checkOutput({tag, "_req_valid"}, mem_req_valid_o, 0);
    checkOutput({tag, "_req_addr"}, mem_req_addr_o, 0);
    checkOutput({tag, "_refill_valid"}, refill_valid_o, 0);
    checkOutput({tag, "_refill_index"}, refill_index_o, 0);
    checkOutput({tag, "_refill_tag"}, refill_tag_o, 0);
    checkOutput({tag, "_refill_way"}, refill_way_o, 0);
    checkOutput({tag, "_refill_data"}, refill_data_o, 0);
    checkOutput({tag, "_refill_err"}, refill_err_o, 0);
  endtask

  // Scoreboard consumer: every write strobe must match the oldest entry.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (refill_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("refill_expected", refill_valid_o, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("sb_index", refill_index_o, e.index);
          checkOutput("sb_tag", refill_tag_o, e.tag);
          checkOutput("sb_way", refill_way_o, e.way);
          checkOutput("sb_data", refill_data_o, e.data);
          checkOutput("sb_err", refill_err_o, e.err);
        end
      end
    end
  end

  // mode: 0 normal, 1 flush in REQ (needs req_wait>0), 2 flush with beat 2,
  // 3 flush in WRITE, 4 flush in the acceptance cycle, 5 reset after beat 2.
  // A gap of gap_len idle cycles follows beat 1. When req_wait>0 a junk
  // errored beat is driven in the acceptance cycle and must be ignored.
  task automatic applyStimulus(input logic [PLEN-1:0] paddr, input logic [WAY_W-1:0] way,
                               input logic [7:0] base, input int req_wait, input int gap_len,
                               input logic [BEATS-1:0] err_mask, input int mode);
    logic [PLEN-1:0]       aligned;
    logic [BUS_WIDTH-1:0]  beat [BEATS];
    logic [LINE_WIDTH-1:0] line;
    logic [7:0]            byt;
    logic                  will_refill;
    exp_t                  e;

    aligned     = {paddr[PLEN-1:5], 5'b0};
    will_refill = (mode == 0) || (mode == 4);
    for (int b = 0; b < BEATS; b++) begin
      byt = base + 8'(b * 17);
      beat[b] = {8{byt}};
      line[b*BUS_WIDTH +: BUS_WIDTH] = beat[b];
    end

    @(negedge clk_i);
    checkOutput("miss_ready_idle", miss_ready_o, 1);
    miss_valid_i = 1'b1;
    miss_paddr_i = paddr;
    miss_way_i   = way;
    flush_i      = (mode == 4);
    if (will_refill) begin
      e.index = aligned[5 +: INDEX_WIDTH];
      e.tag   = paddr[PLEN-1 -: TAG_W];
      e.way   = way;
      e.data  = line;
      e.err   = |err_mask;
      exp_q.push_back(e);
    end

    @(negedge clk_i);
    miss_valid_i = 1'b0;
    flush_i      = 1'b0;
    miss_paddr_i = $urandom;
    miss_way_i   = WAY_W'($urandom);
    checkOutput("req_valid", mem_req_valid_o, 1);
    checkOutput("req_addr", mem_req_addr_o, aligned);
    checkOutput("miss_ready_busy", miss_ready_o, 0);

    for (int i = 0; i < req_wait; i++) begin
      mem_req_ready_i = 1'b0;
      flush_i         = (mode == 1) && (i == 0);
      @(negedge clk_i);
      flush_i = 1'b0;
      checkOutput("req_valid_hold", mem_req_valid_o, 1);
      checkOutput("req_addr_hold", mem_req_addr_o, aligned);
    end
    mem_req_ready_i = 1'b1;
    if (req_wait > 0) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
      mem_rsp_err_i   = 1'b1;
    end

    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;

    for (int b = 0; b < BEATS; b++) begin
      if (mode == 5 && b == 3) begin
        #3;
        rst_ni = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        return;
      end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = beat[b];
      mem_rsp_err_i   = err_mask[b];
      flush_i         = (mode == 2) && (b == 2);
      if (b == BEATS - 1) begin
        checkOutput("no_early_refill", refill_valid_o, 0);
      end
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      mem_rsp_err_i   = 1'b0;
      flush_i         = 1'b0;
      if (b == 1) begin
        for (int g = 0; g < gap_len; g++) begin
          checkOutput("miss_ready_gap", miss_ready_o, 0);
          @(negedge clk_i);
        end
      end
    end

    flush_i = (mode == 3);
    #1;
    checkOutput("refill_strobe", refill_valid_o, will_refill);
    checkOutput("miss_ready_write", miss_ready_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("refill_one_cycle", refill_valid_o, 0);
    checkOutput("miss_ready_back", miss_ready_o, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni          = 1'b0;
    flush_i         = 1'b0;
    miss_valid_i    = 1'b0;
    miss_paddr_i    = '0;
    miss_way_i      = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_err_i   = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] basic refill");
    applyStimulus(32'h8000_1234, 2'd2, 8'h11, 0, 0, 4'b0000, 0);
    @(negedge clk_i);
    checkOutput("basic_index_held", refill_index_o, 6'h11);
    checkOutput("basic_tag_held", refill_tag_o, 21'h100002);
    checkOutput("basic_way_held", refill_way_o, 2'd2);
    checkOutput("basic_data_held", refill_data_o,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    checkOutput("basic_err_held", refill_err_o, 0);

    $display("[TB] stalls");
    applyStimulus(32'h8000_1234, 2'd2, 8'h11, 3, 2, 4'b0000, 0);

    $display("[TB] error beat then clean miss");
    applyStimulus(32'h1234_5678, 2'd1, 8'h5A, 0, 0, 4'b0100, 0);
    applyStimulus(32'h0000_0FC0, 2'd3, 8'h01, 1, 0, 4'b0000, 0);

    $display("[TB] flush in RECV then normal miss");
    applyStimulus(32'hA5A5_0040, 2'd0, 8'h20, 0, 0, 4'b0000, 2);
    applyStimulus(32'hA5A5_0040, 2'd0, 8'h30, 0, 0, 4'b0000, 0);

    $display("[TB] flush in REQ, in WRITE, and at acceptance");
    applyStimulus(32'h4000_0100, 2'd1, 8'h40, 2, 0, 4'b0000, 1);
    applyStimulus(32'h4000_0100, 2'd1, 8'h50, 0, 0, 4'b0000, 3);
    applyStimulus(32'h7FFF_FFE0, 2'd3, 8'h60, 0, 1, 4'b0000, 4);

    $display("[TB] async reset in RECV then new miss");
    applyStimulus(32'h1357_9BDF, 2'd2, 8'h70, 0, 0, 4'b0000, 5);
    applyStimulus(32'hFFFF_FFFF, 2'd1, 8'h80, 0, 0, 4'b0000, 0);

    $display("[TB] random misses");
    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom, WAY_W'($urandom_range(0, 3)), 8'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    BEATS'($urandom_range(0, 15)), 0);
    end

    repeat (3) @(negedge clk_i);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
